// File: rtl/imm_decode_stage_if.sv
// Purpose : handshake bundle for imm_decode_stage. It carries the upstream
//           instruction/PC/tag entry and the downstream decoded entry.
// Modports: master - the producer/consumer side (drives in_*, out_ready)
//           slave  - the decode stage itself
// Signals : in_valid/in_ready/in_instr/in_pc/in_tag,
//           out_valid/out_ready/out_imm/out_fmt/out_illegal/out_pc/out_tag
interface imm_decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [XLEN-1:0]  out_pc;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_pc, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_tag
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Purpose : registered RV32I immediate-generation stage. The immediate format
//           is derived from the opcode, the result is sign-extended to XLEN,
//           and a main/skid register pair gives 1-cycle latency with full
//           throughput under back-pressure.
// Ports   : clk   - rising-edge clock
//           rst   - asynchronous active-high reset
//           flush - drops every buffered entry and the input of this cycle
//           bus   - imm_decode_stage_if.slave (input and output handshakes)
module imm_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  imm_decode_stage_if.slave  bus
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t      dec;
  entry_t      m_q, m_d, k_q, k_d;
  logic        m_valid_q, m_valid_d, k_valid_q, k_valid_d;
  logic [31:0] imm32;
  logic        accept;
  logic        m_free;

  // Opcode-driven immediate decode of the incoming instruction
  always_comb begin
    logic [31:0] ins;
    ins         = bus.in_instr;
    imm32       = 32'd0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    dec.pc      = bus.in_pc;
    dec.tag     = bus.in_tag;
    case (ins[6:0])
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm32   = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0010011: begin
        if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
          dec.fmt = FMT_SHAMT;
          imm32   = {27'd0, ins[24:20]};
        end else begin
          dec.fmt = FMT_I;
          imm32   = {{20{ins[31]}}, ins[31:20]};
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {ins[31:12], 12'd0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b0110011, 7'b0001111: begin
        dec.fmt = FMT_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    // Shamt is non-negative, so sign extension is also a zero extension there
    dec.imm = XLEN'($signed(imm32));
  end

  // Skid empty is the only condition for taking an entry
  assign accept = bus.in_valid && !k_valid_q && !flush;
  assign m_free = !m_valid_q || bus.out_ready;

  // Main/skid next state; data fields only change when loaded
  always_comb begin
    m_d       = m_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (m_free) begin
      if (k_valid_q) begin
        // Skid full implies no accept this cycle, so K simply drains into M
        m_d       = k_q;
        m_valid_d = 1'b1;
        k_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = dec;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      k_d       = dec;
      k_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
    end
  end

  assign bus.in_ready    = !k_valid_q;
  assign bus.out_valid   = m_valid_q;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_fmt     = m_q.fmt;
  assign bus.out_illegal = m_q.illegal;
  assign bus.out_pc      = m_q.pc;
  assign bus.out_tag     = m_q.tag;

endmodule
